// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, FSM encoding and round/schedule helper functions.
package sha256_pkg;
  localparam int WORD = 32;
  typedef logic [WORD-1:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic word_t e0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction
  function automatic word_t e1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction
  function automatic word_t s0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic word_t s1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
endpackage

// File: rtl/sha256_round_ctrl_if.sv
// sha256_round_ctrl_if: block-in / digest-out handshake bundle.
interface sha256_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic [511:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_digest;
  logic         busy;
  modport master (output in_valid, in_first, in_block, out_ready,
                  input in_ready, out_valid, out_digest, busy);
  modport slave (input in_valid, in_first, in_block, out_ready,
                 output in_ready, out_valid, out_digest, busy);
endinterface

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word sliding message-schedule window; W_t is always w[0].
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [511:0] i_block,
  output word_t        o_wt
);
  word_t r_w [16];
  word_t w_new;
  assign w_new = s1(r_w[14]) + r_w[9] + s0(r_w[1]) + r_w[0];
  assign o_wt = r_w[0];
  always_ff @(posedge clk) begin
    if (i_load) begin
      for (int i = 0; i < 16; i++) r_w[i] <= i_block[511-32*i -: 32];
    end else if (i_shift) begin
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_new;
    end
  end
endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: 64-round SHA-256 compression sequencer with chaining hash.
module sha256_round_ctrl
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  sha256_round_ctrl_if.slave bus
);
  state_t       r_state, w_next;
  logic [5:0]   r_t;
  word_t        r_wk [8];
  logic [255:0] r_hash;
  logic [255:0] w_hinit;
  word_t        w_wt, w_t1, w_t2;
  logic         w_accept;
  sha256_msg_sched u_sched (
    .clk    (clk),
    .i_load (w_accept),
    .i_shift(r_state == S_ROUND),
    .i_block(bus.in_block),
    .o_wt   (w_wt)
  );
  assign w_hinit = bus.in_first ? IV : r_hash;
  assign w_t1 = r_wk[7] + e1(r_wk[4]) + ch(r_wk[4], r_wk[5], r_wk[6]) + K[r_t] + w_wt;
  assign w_t2 = e0(r_wk[0]) + maj(r_wk[0], r_wk[1], r_wk[2]);
  always_comb begin
    w_accept = bus.in_valid && r_state == S_IDLE;
    w_next = r_state == S_IDLE  ? (w_accept ? S_ROUND : S_IDLE) :
             r_state == S_ROUND ? (r_t == 6'd63 ? S_FINAL : S_ROUND) :
             r_state == S_FINAL ? S_DONE :
             (bus.out_ready ? S_IDLE : S_DONE);
    bus.in_ready = r_state == S_IDLE;
    bus.out_valid = r_state == S_DONE;
    bus.busy = r_state == S_ROUND || r_state == S_FINAL;
    bus.out_digest = r_hash;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_t <= '0;
      r_hash <= IV;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_t <= '0;
        if (bus.in_first) r_hash <= IV;
        for (int i = 0; i < 8; i++) r_wk[i] <= w_hinit[255-32*i -: 32];
      end
      if (r_state == S_ROUND) begin
        r_t <= r_t + 6'd1;
        r_wk[0] <= w_t1 + w_t2;
        r_wk[1] <= r_wk[0];
        r_wk[2] <= r_wk[1];
        r_wk[3] <= r_wk[2];
        r_wk[4] <= r_wk[3] + w_t1;
        r_wk[5] <= r_wk[4];
        r_wk[6] <= r_wk[5];
        r_wk[7] <= r_wk[6];
      end
      if (r_state == S_FINAL) begin
        for (int i = 0; i < 8; i++) r_hash[255-32*i -: 32] <= r_hash[255-32*i -: 32] + r_wk[i];
      end
    end
  end
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: scoreboard bench against a full-schedule SHA-256 reference model.
module tb_sha256_round_ctrl;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  sha256_round_ctrl_if bus();
  sha256_round_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct { logic [255:0] dig; int acc; } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rmode = 0;
  int last_acc = 0;
  logic seen = 0;
  logic [255:0] held;
  logic [255:0] mh;
  localparam logic [255:0] TIV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2 = {480'h0, 32'h000001c0};
  logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction
  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s", nm);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end
  // Monitor: latency on first out_valid, hold stability under backpressure, digest on handshake.
  always @(negedge clk) begin
    if (rst) seen = 0;
    else if (bus.out_valid) begin
      if (!seen) begin
        seen = 1;
        held = bus.out_digest;
        if (q.size() == 0) fail("unexpected_out_valid");
        else chk("latency", 256'(cyc + 1 - q[0].acc), 256'(66));
      end else begin
        chk("digest_hold", bus.out_digest, held);
        chk("in_ready_in_done", 256'(bus.in_ready), 256'(0));
      end
      if (bus.out_ready) begin
        if (q.size() != 0) begin
          chk("digest", bus.out_digest, q[0].dig);
          void'(q.pop_front());
        end
        seen = 0;
      end
    end
  end
  task automatic send(input logic [511:0] blk, input logic first, input logic [255:0] known,
                      input logic use_known, input logic hold, input logic chk_gap);
    int w = 0;
    logic [255:0] m;
    bus.in_valid = 1'b1;
    bus.in_block = blk;
    bus.in_first = first;
    @(negedge clk);
    while (!bus.in_ready && w < 300) begin
      w++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      fail("accept_timeout");
      bus.in_valid = 1'b0;
      return;
    end
    if (first) mh = TIV;
    m = compress(mh, blk);
    mh = m;
    if (chk_gap) chk("accept_gap", 256'(cyc + 1 - last_acc), 256'(67));
    last_acc = cyc + 1;
    q.push_back('{use_known ? known : m, cyc + 1});
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || bus.out_valid) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string nm);
    @(negedge clk);
    chk({nm, "_in_ready"}, 256'(bus.in_ready), 256'(1));
    chk({nm, "_out_valid"}, 256'(bus.out_valid), 256'(0));
    chk({nm, "_busy"}, 256'(bus.busy), 256'(0));
    chk({nm, "_digest"}, bus.out_digest, TIV);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [511:0] blk;
    int w;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_block = '0;
    mh = TIV;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check_idle("reset");
    send(B_ABC, 1, D_ABC, 1, 0, 0);
    drain();
    send(B_EMPTY, 1, D_EMPTY, 1, 0, 0);
    drain();
    send(B_TWO1, 1, '0, 0, 0, 0);
    send(B_TWO2, 0, D_TWO, 1, 0, 0);
    drain();
    rmode = 2;
    send(B_ABC, 1, D_ABC, 1, 0, 0);
    w = 0;
    while (!bus.out_valid && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!bus.out_valid) fail("backpressure_valid_timeout");
    repeat (10) @(posedge clk);
    #1;
    rmode = 0;
    drain();
    send(B_ABC, 1, D_ABC, 1, 1, 0);
    send(B_ABC, 1, D_ABC, 1, 0, 1);
    drain();
    send(B_TWO1, 1, '0, 0, 0, 0);
    send(B_TWO2, 0, '0, 0, 0, 0);
    repeat (30) @(posedge clk);
    #1;
    rst = 1;
    q.delete();
    mh = TIV;
    @(posedge clk);
    #1;
    rst = 0;
    check_idle("midreset");
    repeat (80) @(posedge clk);
    #1;
    send(B_ABC, 0, D_ABC, 1, 0, 0);
    drain();
    rmode = 1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 16; i++) blk[i*32 +: 32] = $urandom();
      send(blk, ($urandom_range(0, 3) == 0), '0, 0, 1'($urandom_range(0, 1)), 0);
    end
    bus.in_valid = 1'b0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
- Sequences the SHA-256 compression of one 512-bit block over 64 single-cycle rounds, driving the e0/e1/ch/maj/s0/s1 function blocks.
- Owns the round counter, the K constant selection, the 16-word message-schedule window, working registers a..h and the chaining hash H0..H7.
- Sits between the padding/block feeder (upstream valid/ready) and the digest consumer (downstream valid/ready).

Parameters:
- None. The SHA-256 geometry is fixed: 64 rounds, 32-bit words, 512-bit block, 256-bit digest.

Ports:
- clk  in  1  Rising-edge clock; the only clock.
- rst  in  1  Synchronous, active-high reset.
- in_valid  in  1  Block available.
- in_ready  out  1  Controller accepts a block this cycle.
- in_first  in  1  Sampled with the block. 1 = start from IV; 0 = chain from the current H.
- in_block  in  512  Message block. [511:480] = W0, [31:0] = W15 (big-endian word order).
- out_valid  out  1  Digest valid.
- out_ready  in  1  Consumer accepts the digest.
- out_digest  out  256  H0..H7. [255:224] = H0.
- busy  out  1  High in ROUND or FINAL.

Behaviour:
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0; round counter = 0.
  - H0..H7 = SHA-256 IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - out_digest reflects H, so it equals the IV after reset.
- Reset mid-operation: the in-flight block is discarded with no partial output; rst dominates all other inputs.
- FSM states: IDLE, ROUND, FINAL, DONE. in_ready = (state == IDLE).
- IDLE:
  - Accept when in_valid & in_ready.
  - Load the schedule window w[0..15] from in_block.
  - If in_first = 1, load H with the IV first. Load a..h from the (possibly reloaded) H.
  - Clear the round counter t; next state ROUND.
- ROUND, one round per cycle for t = 0..63:
  - T1 = h + e1(e) + ch(e,f,g) + K[t] + w[0]
  - T2 = e0(a) + maj(a,b,c)
  - Update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - All additions are modulo 2^32; carries out of bit 31 are dropped.
  - Window update: w[i] <= w[i+1] for i = 0..14; w[15] <= s1(w[14]) + w[9] + s0(w[1]) + w[0].
  - The window update is identical on every round; the words it produces after round 47 are unused.
  - At t = 63, go to FINAL. t wraps to 0 and is not otherwise used.
- FINAL: Hi <= Hi + reg_i (mod 2^32) for all eight words; next state DONE.
- DONE:
  - out_valid = 1; out_digest holds stable while out_valid & !out_ready.
  - On out_ready, go to IDLE.
  - in_ready is 0 in DONE, so there is one bubble cycle between blocks.
- Latency: accept edge at cycle 0 -> rounds on cycles 1..64 -> FINAL on cycle 65 -> out_valid first high on cycle 66.
- Throughput: one block per 67 cycles when out_ready is tied high.
- Chaining:
  - in_first = 0 always uses the last H, including the final H of a prior message.
  - in_first = 0 as the first block after reset is equivalent to in_first = 1, since H is reset to the IV.
- in_block and in_first are ignored outside an IDLE accept.

Decomposition:
- Package sha256_pkg holds:
  - the K[0..63] constant function/table;
  - the IV constants;
  - the FSM state encodings (2 bits);
  - the word-width constant 32.
- Sub-module sha256_msg_sched holds:
  - the 16 x 32-bit window, with load and shift controls;
  - the s0/s1 instances;
  - output W_t = w[0].
- The controller instantiates e0, e1, ch and maj directly.

Test Plan:
- "abc": block 61626380_0..._00000018, in_first=1 -> out_valid exactly 66 cycles after accept; digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: block 80000000_0...0, in_first=1 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": first block with in_first=1, second with in_first=0 -> final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: "abc" with out_ready held low for 10 cycles after out_valid -> out_valid and digest stable throughout; in_ready stays 0; completes on the first out_ready.
- Reset mid-round: assert rst at round 30 of the second chained block, then send "abc" with in_first=0 -> IV digest of "abc" (ba7816bf...); out_valid never pulses for the aborted block.
- Back-to-back: in_valid held high with two "abc" blocks, both in_first=1, and out_ready=1 -> second accept exactly 67 cycles after the first; both digests correct.
